// File: rtl/elevator_controller.sv
// rtl/elevator_controller.sv - three-floor elevator car controller with request register and car FSM
// Purpose: conditions the raw call buttons and the slow step clock, keeps the pending
//   request bits and runs the car state machine (IDLE / MOVE_UP / MOVE_DOWN / DOOR_OPEN).
// Ports:
//   clk_50     in   system clock, all flops on its rising edge
//   rst_n      in   asynchronous active-low reset
//   clk        in   slow step clock from the frequency divisor (asynchronous)
//   button1..3 in   active-low floor calls, raw
//   moving     out  car travelling between floors
//   floor      out  current floor 1..3
//   dir_up     out  last or current travel direction is up
//   door_open  out  door open
//   requests   out  pending calls, bit0 = floor 1
// Optional feature macro: DOOR_HOLD_EN (current-floor press re-arms the open door).
module elevator_controller #(
    parameter int TRAVEL_TICKS = 2,
    parameter int DOOR_TICKS   = 3
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       clk,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    output logic       moving,
    output logic [1:0] floor,
    output logic       dir_up,
    output logic       door_open,
    output logic [2:0] requests
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    localparam logic [3:0] TRAVEL_LD = 4'(TRAVEL_TICKS);
    localparam logic [3:0] DOOR_LD   = 4'(DOOR_TICKS);

    // Input conditioning: two synchroniser flops, one history flop for edge detect,
    // and a registered pulse so a press lands 3 cycles after the button edge.
    logic [2:0] btn_s1_q, btn_s2_q, btn_s3_q, press_q;
    logic       clk_s1_q, clk_s2_q, clk_s3_q, tick_q;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q <= 3'b111;
            btn_s2_q <= 3'b111;
            btn_s3_q <= 3'b111;
            press_q  <= 3'b000;
            clk_s1_q <= 1'b0;
            clk_s2_q <= 1'b0;
            clk_s3_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            btn_s1_q <= {button3, button2, button1};
            btn_s2_q <= btn_s1_q;
            btn_s3_q <= btn_s2_q;
            press_q  <= btn_s3_q & ~btn_s2_q;
            clk_s1_q <= clk;
            clk_s2_q <= clk_s1_q;
            clk_s3_q <= clk_s2_q;
            tick_q   <= clk_s2_q & ~clk_s3_q;
        end
    end

    function automatic logic [2:0] onehot_of(input logic [1:0] f);
        case (f)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic above_of(input logic [1:0] f, input logic [2:0] r);
        case (f)
            2'd1:    return r[1] | r[2];
            2'd2:    return r[2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic below_of(input logic [1:0] f, input logic [2:0] r);
        case (f)
            2'd3:    return r[0] | r[1];
            2'd2:    return r[0];
            default: return 1'b0;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [1:0] floor_q, floor_d;
    logic       dir_up_q, dir_up_d;
    logic [3:0] trav_cnt_q, trav_cnt_d;
    logic [3:0] door_cnt_q, door_cnt_d;
    logic [2:0] req_q, req_d;
    logic       moving_q, door_open_q;

    logic [2:0] cur_mask, blk_mask, req_clr;
    logic       press_here, req_here, req_above, req_below, want_up, want_down;
    logic       hold;
    logic [1:0] next_floor;

    assign cur_mask   = onehot_of(floor_q);
    assign press_here = |(press_q & cur_mask);
    assign req_here   = |(req_q & cur_mask);
    assign req_above  = above_of(floor_q, req_q);
    assign req_below  = below_of(floor_q, req_q);
    // With calls on both sides, keep going the way dir_up points.
    assign want_up    = req_above & (dir_up_q | ~req_below);
    assign want_down  = req_below & ~want_up;
    // A current-floor press never sets its bit while parked or with the door open.
    assign blk_mask   = (state_q == IDLE || state_q == DOOR_OPEN) ? cur_mask : 3'b000;

`ifdef DOOR_HOLD_EN
    assign hold = press_here;
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_up_d   = dir_up_q;
        trav_cnt_d = trav_cnt_q;
        door_cnt_d = door_cnt_q;
        req_clr    = 3'b000;
        next_floor = floor_q;

        case (state_q)
            IDLE: begin
                if (req_here || press_here) begin
                    state_d    = DOOR_OPEN;
                    door_cnt_d = DOOR_LD;
                    req_clr    = cur_mask;
                end else if (want_up) begin
                    state_d    = MOVE_UP;
                    dir_up_d   = 1'b1;
                    trav_cnt_d = TRAVEL_LD;
                end else if (want_down) begin
                    state_d    = MOVE_DOWN;
                    dir_up_d   = 1'b0;
                    trav_cnt_d = TRAVEL_LD;
                end
            end

            MOVE_UP, MOVE_DOWN: begin
                if (tick_q) begin
                    if (trav_cnt_q <= 4'd1) begin
                        if (state_q == MOVE_UP) begin
                            next_floor = (floor_q == 2'd3) ? 2'd3 : floor_q + 2'd1;
                        end else begin
                            next_floor = (floor_q == 2'd1) ? 2'd1 : floor_q - 2'd1;
                        end
                        floor_d = next_floor;
                        if (|(req_q & onehot_of(next_floor))) begin
                            state_d    = DOOR_OPEN;
                            door_cnt_d = DOOR_LD;
                            req_clr    = onehot_of(next_floor);
                        end else if ((state_q == MOVE_UP) ? above_of(next_floor, req_q)
                                                          : below_of(next_floor, req_q)) begin
                            trav_cnt_d = TRAVEL_LD;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        trav_cnt_d = trav_cnt_q - 4'd1;
                    end
                end
            end

            DOOR_OPEN: begin
                if (hold) begin
                    door_cnt_d = DOOR_LD;
                end else if (tick_q) begin
                    if (door_cnt_q <= 4'd1) begin
                        if (want_up) begin
                            state_d    = MOVE_UP;
                            dir_up_d   = 1'b1;
                            trav_cnt_d = TRAVEL_LD;
                        end else if (want_down) begin
                            state_d    = MOVE_DOWN;
                            dir_up_d   = 1'b0;
                            trav_cnt_d = TRAVEL_LD;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        door_cnt_d = door_cnt_q - 4'd1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Set wins over clear when both hit the same bit in one cycle.
        req_d = (req_q & ~req_clr) | (press_q & ~blk_mask);
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            floor_q     <= 2'd1;
            dir_up_q    <= 1'b1;
            trav_cnt_q  <= 4'd0;
            door_cnt_q  <= 4'd0;
            req_q       <= 3'b000;
            moving_q    <= 1'b0;
            door_open_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            dir_up_q    <= dir_up_d;
            trav_cnt_q  <= trav_cnt_d;
            door_cnt_q  <= door_cnt_d;
            req_q       <= req_d;
            moving_q    <= (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
            door_open_q <= (state_d == DOOR_OPEN);
        end
    end

    assign moving    = moving_q;
    assign floor     = floor_q;
    assign dir_up    = dir_up_q;
    assign door_open = door_open_q;
    assign requests  = req_q;

endmodule

// File: doc/elevator_controller.md
Name: elevator_controller

Overview:
- Three-floor elevator car controller, all logic on the 50 MHz board clock.
- Consumes the three active-low call buttons and the slow step clock produced by the frequency divisor.
- Produces `moving`, which feeds back into the divisor, plus the floor, direction, door and pending-request outputs for the display logic.
- Holds the request register and the car state machine.

Parameters:
- TRAVEL_TICKS, 2, slow-clock ticks needed to move one floor (range 1..15).
- DOOR_TICKS, 3, slow-clock ticks the door stays open (range 1..15).

Ports:
- clk_50  in  1  50 MHz system clock; every flop is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clk  in  1  slow step clock from the frequency divisor; asynchronous to clk_50.
- button1  in  1  floor-1 call, active-low, idle 1, raw and unsynchronised.
- button2  in  1  floor-2 call, active-low, idle 1.
- button3  in  1  floor-3 call, active-low, idle 1.
- moving  out  1  high while the car is travelling between floors.
- floor  out  2  current floor, 2'd1..2'd3; 2'd0 is never driven.
- dir_up  out  1  1 = last or current travel direction is up.
- door_open  out  1  high while the door is open.
- requests  out  3  pending calls; bit0 = floor 1, bit2 = floor 3.

Behaviour:
- Reset (asynchronous, active-low):
  - Outputs: floor = 1, dir_up = 1, moving = 0, door_open = 0, requests = 3'b000.
  - FSM goes to IDLE; counters cleared; synchroniser flops preset to 1 (buttons) and 0 (clk).
  - Reset asserted mid-travel or mid-door aborts at once; no state is retained.
- Input conditioning:
  - Each button passes through a 2-flop synchroniser, then a falling-edge detect.
  - A 1-cycle `press` pulse occurs 3 clk_50 cycles after the falling edge.
  - Holding a button low produces exactly one press.
  - `clk` gets the same synchroniser with rising-edge detect, giving a 1-cycle `tick`.
- Request register:
  - A press sets its bit the following cycle.
  - A press for a bit already set has no effect.
  - Press for the current floor while IDLE: the bit is not set; the car goes to DOOR_OPEN instead.
  - Press for the current floor while DOOR_OPEN: see the optional feature.
  - A set and a clear of the same bit in one cycle resolves to set.
- FSM states: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- IDLE (ticks ignored):
  - A request or press at the current floor goes to DOOR_OPEN first.
  - Otherwise a request above goes to MOVE_UP; a request below goes to MOVE_DOWN.
  - If requests exist both above and below (floor 2 with bits 0 and 2 set), follow dir_up.
  - The decision takes 1 clk_50 cycle; it does not wait for a tick.
- MOVE_UP / MOVE_DOWN:
  - moving = 1 and dir_up is set accordingly.
  - The travel counter loads TRAVEL_TICKS on entry and decrements on each tick.
  - When the counter is at 1 and a tick arrives, floor moves ±1 in the same cycle.
  - If the new floor's bit is set: clear it and go to DOOR_OPEN (moving drops the same cycle).
  - Else, if requests remain in the same direction: reload the counter and continue.
  - Else: go to IDLE.
  - floor is saturated at 1 and 3; a move beyond them is unreachable and must never occur.
- DOOR_OPEN:
  - door_open = 1, moving = 0.
  - The door counter loads DOOR_TICKS on entry and decrements on each tick.
  - On expiry, if requests remain in dir_up's direction: move that way.
  - Else, if requests remain in the opposite direction: reverse (dir_up toggles on entry).
  - Else: go to IDLE.
- moving and door_open are never both high; both are registered outputs.

Optional Feature:
- Macro: DOOR_HOLD_EN.
- Defined: a press for the current floor during DOOR_OPEN reloads the door counter to DOOR_TICKS; the request bit stays clear.
- Undefined: that press is ignored entirely (no reload, bit not set). The door closes on the original schedule.

Test Plan (TRAVEL_TICKS = 2, DOOR_TICKS = 3, divisor clk period 20 clk_50 cycles):
- Reset check: pulse rst_n low mid-run -> floor=1, moving=0, door_open=0, requests=0 within the same cycle, asynchronously.
- Single call: at floor 1, press button3 -> requests=3'b100 after 4 cycles; moving=1 and dir_up=1 on the next cycle; floor=2 after 2 ticks; floor=3 after 4 ticks with door_open=1, moving=0, requests=0; IDLE after 3 more ticks.
- Current-floor press: at floor 1, IDLE, press button1 -> door_open=1 without moving; requests stays 000.
- Pass-through collect: at floor 1, press button3, then press button2 before floor 2 is reached -> car stops at 2 (door 3 ticks), then continues to 3; dir_up stays 1 throughout.
- Reversal: at floor 2 moving up toward 3, press button1 -> after floor-3 door expiry, dir_up=0 and the car travels to floor 1.
- Held button and door hold: keep button2 low for 100 cycles -> exactly one request. With DOOR_HOLD_EN, press the current floor's button at door tick 2 -> door_open lasts 2 + 3 ticks; without the macro it lasts 3 ticks.
